// File: rtl/hold_dma_copier_pkg.sv
// rtl/hold_dma_copier_pkg.sv - shared types and defaults for the HOLD/HLDA block-copy engine
// Purpose: FSM state encoding and default bus/length/timeout widths used by
//          hold_dma_copier and its hold timer.
// Ports:   none (package)
package hold_dma_copier_pkg;

  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_LEN_W        = 8;
  localparam int DEF_HOLD_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_REL  = 3'd4
  } state_t;

endpackage

// File: rtl/hold_dma_copier_hold_timer.sv
// rtl/hold_dma_copier_hold_timer.sv - HLDA wait counter with clear/count/expire
// Purpose: counts REQ cycles spent waiting for HLDA; expire is high during the
//          TIMEOUT-th waiting cycle so the FSM leaves REQ after exactly TIMEOUT cycles.
// Ports:
//   CLK    in  system clock
//   RST    in  asynchronous active-high reset
//   clr    in  restart count from zero (entry to REQ)
//   en     in  count one waiting cycle
//   expire out current waiting cycle is the last one allowed
module hold_dma_copier_hold_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expire) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // cnt_q holds the number of waiting cycles already completed.
  assign expire = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/hold_dma_copier.sv
// rtl/hold_dma_copier.sv - memory-to-memory copier that borrows the bus via HOLD/HLDA
// Purpose: on START latches src/dst/len, raises HOLD, waits for HLDA, then copies
//          one byte every two cycles (RD then WR), releases the bus and pulses DONE.
//          HLDA timeout or HLDA loss mid-copy sets sticky ERR and releases the bus.
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   START                 one-cycle request, honoured only in IDLE
//   SRC_ADDR, DST_ADDR    first source/destination address, latched on START
//   LEN                   byte count, latched on START (0 = immediate DONE)
//   BUSY, DONE, ERR       status: busy window, completion pulse, sticky error
//   HOLD, HLDA            bus request to CPU / bus grant from CPU
//   MEM_ADDR, MEM_RE, MEM_WE, MEM_WDATA, MEM_RDATA, BUS_EN   memory bus side
module hold_dma_copier
  import hold_dma_copier_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int LEN_W        = DEF_LEN_W,
  parameter int HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] SRC_ADDR,
  input  logic [ADDR_W-1:0] DST_ADDR,
  input  logic [LEN_W-1:0]  LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              HOLD,
  input  logic              HLDA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RE,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUS_EN
);

  state_t state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_d;
  logic busy_d, done_d, err_d, hold_d, re_d, we_d;
  logic tmr_clr, tmr_en, tmr_expire;

  hold_dma_copier_hold_timer #(.TIMEOUT(HOLD_TIMEOUT)) u_hold_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      HOLD      <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_RE    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_WDATA <= '0;
      BUS_EN    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      ERR       <= err_d;
      HOLD      <= hold_d;
      MEM_ADDR  <= addr_d;
      MEM_RE    <= re_d;
      MEM_WE    <= we_d;
      MEM_WDATA <= wdata_d;
      BUS_EN    <= re_d | we_d;
    end
  end

  // Next-state logic computes the value every output takes in the following
  // cycle, so strobes and address are registered and glitch-free on the bus.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    busy_d  = BUSY;
    done_d  = 1'b0;
    err_d   = ERR;
    hold_d  = HOLD;
    addr_d  = '0;
    re_d    = 1'b0;
    we_d    = 1'b0;
    wdata_d = '0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          err_d = 1'b0;
          if (LEN != '0) begin
            src_d   = SRC_ADDR;
            dst_d   = DST_ADDR;
            cnt_d   = LEN;
            hold_d  = 1'b1;
            busy_d  = 1'b1;
            tmr_clr = 1'b1;
            state_d = ST_REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (HLDA) begin
          addr_d  = src_q;
          re_d    = 1'b1;
          state_d = ST_RD;
        end else if (tmr_expire) begin
          err_d   = 1'b1;
          hold_d  = 1'b0;
          state_d = ST_REL;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_RD: begin
        if (!HLDA) begin
          // Grant lost: the byte just read is dropped, nothing is written.
          err_d   = 1'b1;
          hold_d  = 1'b0;
          state_d = ST_REL;
        end else begin
          addr_d  = dst_q;
          we_d    = 1'b1;
          wdata_d = MEM_RDATA;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        // The write strobe is already on the bus, so this byte is complete
        // whether or not the grant survives the cycle.
        src_d = src_q + ADDR_W'(1);
        dst_d = dst_q + ADDR_W'(1);
        cnt_d = cnt_q - LEN_W'(1);
        if (!HLDA) begin
          err_d   = 1'b1;
          hold_d  = 1'b0;
          state_d = ST_REL;
        end else if (cnt_q == LEN_W'(1)) begin
          hold_d  = 1'b0;
          state_d = ST_REL;
        end else begin
          addr_d  = src_q + ADDR_W'(1);
          re_d    = 1'b1;
          state_d = ST_RD;
        end
      end
      ST_REL: begin
        hold_d = 1'b0;
        if (!HLDA) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hold_dma_copier.sv
// tb/tb_hold_dma_copier.sv - scoreboard bench for hold_dma_copier
module tb_hold_dma_copier;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [15:0] SRC_ADDR = '0;
  logic [15:0] DST_ADDR = '0;
  logic [7:0]  LEN = '0;
  logic        BUSY, DONE, ERR, HOLD;
  logic        HLDA = 1'b0;
  logic [15:0] MEM_ADDR;
  logic        MEM_RE, MEM_WE, BUS_EN;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  MEM_RDATA;

  logic [7:0]  mem [0:65535];

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_rd_q[$];
  logic [23:0] exp_wr_q[$];
  logic        exp_done_q[$];

  bit sb_en = 1'b1;
  bit tie0 = 1'b0;
  bit drop_after_we = 1'b0;
  int grant_delay = 2;

  int hold_cyc = 0, re_cnt = 0, we_cnt = 0, done_cnt = 0, busy_cyc = 0;

  hold_dma_copier #(
    .ADDR_W(16), .DATA_W(8), .LEN_W(8), .HOLD_TIMEOUT(8)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR),
    .LEN(LEN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .HOLD(HOLD), .HLDA(HLDA),
    .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .BUS_EN(BUS_EN)
  );

  assign MEM_RDATA = mem[MEM_ADDR];

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory write port of the bench memory.
  initial forever begin
    @(posedge CLK);
    if (MEM_WE) mem[MEM_ADDR] = MEM_WDATA;
  end

  // CPU side: grants HOLD after grant_delay cycles, drops HLDA when HOLD falls.
  initial begin
    int hcnt;
    bit dropped;
    hcnt = 0;
    dropped = 1'b0;
    forever begin
      @(negedge CLK);
      if (!HOLD || tie0) begin
        hcnt = 0;
        dropped = 1'b0;
        HLDA = 1'b0;
      end else begin
        hcnt++;
        if (drop_after_we && MEM_WE) dropped = 1'b1;
        HLDA = (hcnt >= grant_delay) && !dropped;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT shows a strobe or DONE.
  initial forever begin
    @(negedge CLK);
    if (HOLD) hold_cyc++;
    if (MEM_RE) re_cnt++;
    if (MEM_WE) we_cnt++;
    if (DONE) done_cnt++;
    if (BUSY) busy_cyc++;
    if (sb_en) begin
      chk("bus_en", {31'd0, BUS_EN}, {31'd0, MEM_RE | MEM_WE});
      chk("re_we_excl", {31'd0, MEM_RE & MEM_WE}, 32'd0);
      if (MEM_RE) begin
        if (exp_rd_q.size() == 0) chk("rd_unexpected", {16'd0, MEM_ADDR}, 32'hFFFF_FFFF);
        else chk("rd_addr", {16'd0, MEM_ADDR}, {16'd0, exp_rd_q.pop_front()});
      end
      if (MEM_WE) begin
        if (exp_wr_q.size() == 0) chk("wr_unexpected", {8'd0, MEM_ADDR, MEM_WDATA}, 32'hFFFF_FFFF);
        else chk("wr_addr_data", {8'd0, MEM_ADDR, MEM_WDATA}, {8'd0, exp_wr_q.pop_front()});
      end
      if (DONE) begin
        if (exp_done_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else chk("done_err", {31'd0, ERR}, {31'd0, exp_done_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_copy(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l);
    @(negedge CLK);
    SRC_ADDR = s;
    DST_ADDR = d;
    LEN = l;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge CLK);
      if (DONE) got = 1'b1;
    end
    chk(name, {31'd0, got}, 32'd1);
    repeat (4) @(negedge CLK);
  endtask

  task automatic chk_idle_out(input string name);
    chk(name, {BUSY, DONE, ERR, HOLD, MEM_RE, MEM_WE, BUS_EN, MEM_ADDR, MEM_WDATA}, 32'd0);
  endtask

  task automatic chk_sb_empty(input string name);
    chk(name, exp_rd_q.size() + exp_wr_q.size() + exp_done_q.size(), 32'd0);
  endtask

  initial begin
    int h0, r0, w0, d0, b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge CLK);
    chk_idle_out("reset_outputs");
    RST = 1'b0;

    // 1: basic 3-byte copy
    mem[16'h0020] = 8'hA1; mem[16'h0021] = 8'hB2; mem[16'h0022] = 8'hC3;
    exp_rd_q = '{16'h0020, 16'h0021, 16'h0022};
    exp_wr_q = '{{16'h0100, 8'hA1}, {16'h0101, 8'hB2}, {16'h0102, 8'hC3}};
    exp_done_q.push_back(1'b0);
    w0 = we_cnt; d0 = done_cnt;
    start_copy(16'h0020, 16'h0100, 8'd3);
    chk("t1_busy", {31'd0, BUSY}, 32'd1);
    chk("t1_hold", {31'd0, HOLD}, 32'd1);
    wait_done("t1_done_seen");
    chk("t1_mem", {8'd0, mem[16'h0100], mem[16'h0101], mem[16'h0102]}, 32'h00A1B2C3);
    chk("t1_we_pulses", we_cnt - w0, 32'd3);
    chk("t1_done_once", done_cnt - d0, 32'd1);
    chk("t1_err_hold_busy", {29'd0, ERR, HOLD, BUSY}, 32'd0);
    chk_sb_empty("t1_sb_empty");

    // 2: LEN=0
    exp_done_q.push_back(1'b0);
    h0 = hold_cyc; r0 = re_cnt; w0 = we_cnt; b0 = busy_cyc;
    start_copy(16'h1234, 16'h5678, 8'd0);
    chk("t2_done_next", {31'd0, DONE}, 32'd1);
    repeat (4) @(negedge CLK);
    chk("t2_no_activity", (hold_cyc - h0) + (re_cnt - r0) + (we_cnt - w0) + (busy_cyc - b0), 32'd0);
    chk_sb_empty("t2_sb_empty");

    // 3: address wrap FFFF -> 0000
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h33; mem[16'h0001] = 8'h44;
    exp_rd_q = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    exp_wr_q = '{{16'h0200, 8'h11}, {16'h0201, 8'h22}, {16'h0202, 8'h33}, {16'h0203, 8'h44}};
    exp_done_q.push_back(1'b0);
    start_copy(16'hFFFE, 16'h0200, 8'd4);
    wait_done("t3_done_seen");
    chk("t3_mem", {mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203]}, 32'h11223344);
    chk_sb_empty("t3_sb_empty");

    // 4: HLDA never granted -> timeout after 8 REQ cycles
    tie0 = 1'b1;
    exp_done_q.push_back(1'b1);
    h0 = hold_cyc; d0 = done_cnt; r0 = re_cnt; w0 = we_cnt;
    start_copy(16'h0300, 16'h0400, 8'd5);
    wait_done("t4_done_seen");
    chk("t4_hold_cycles", hold_cyc - h0, 32'd8);
    chk("t4_err", {31'd0, ERR}, 32'd1);
    chk("t4_done_once", done_cnt - d0, 32'd1);
    chk("t4_no_strobes", (re_cnt - r0) + (we_cnt - w0), 32'd0);
    chk_sb_empty("t4_sb_empty");
    tie0 = 1'b0;

    // 5: HLDA dropped after first write -> only dst+0 written
    mem[16'h0040] = 8'h5A; mem[16'h0041] = 8'h6B; mem[16'h0042] = 8'h7C; mem[16'h0043] = 8'h8D;
    drop_after_we = 1'b1;
    exp_rd_q = '{16'h0040};
    exp_wr_q = '{{16'h0300, 8'h5A}};
    exp_done_q.push_back(1'b1);
    start_copy(16'h0040, 16'h0300, 8'd4);
    wait_done("t5_done_seen");
    chk("t5_mem", {16'd0, mem[16'h0300], mem[16'h0301]}, 32'h00005A00);
    chk("t5_err_sticky", {31'd0, ERR}, 32'd1);
    chk_sb_empty("t5_sb_empty");
    drop_after_we = 1'b0;
    exp_done_q.push_back(1'b0);
    start_copy(16'h0000, 16'h0000, 8'd0);
    chk("t5_err_cleared", {31'd0, ERR}, 32'd0);
    repeat (2) @(negedge CLK);

    // 6: reset during a WR cycle
    begin
      bit seen;
      sb_en = 1'b0;
      seen = 1'b0;
      start_copy(16'h0060, 16'h0600, 8'd4);
      for (int i = 0; i < 50 && !seen; i++) begin
        if (MEM_WE) seen = 1'b1;
        else @(negedge CLK);
      end
      chk("t6_reached_wr", {31'd0, seen}, 32'd1);
      RST = 1'b1;
      #1;
      chk_idle_out("t6_async_reset");
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      sb_en = 1'b1;
      exp_done_q.push_back(1'b0);
      start_copy(16'h0000, 16'h0000, 8'd0);
      chk("t6_idle_after_reset", {30'd0, DONE, HOLD}, 32'd2);
      repeat (2) @(negedge CLK);
      chk_sb_empty("t6_sb_empty");
    end

    // 7: START while busy is ignored
    mem[16'h0050] = 8'h9A; mem[16'h0051] = 8'hAB; mem[16'h0052] = 8'hBC;
    mem[16'h0060] = 8'h01; mem[16'h0500] = 8'hEE;
    exp_rd_q = '{16'h0050, 16'h0051, 16'h0052};
    exp_wr_q = '{{16'h0400, 8'h9A}, {16'h0401, 8'hAB}, {16'h0402, 8'hBC}};
    exp_done_q.push_back(1'b0);
    d0 = done_cnt;
    start_copy(16'h0050, 16'h0400, 8'd3);
    @(negedge CLK);
    chk("t7_busy_at_restart", {31'd0, BUSY}, 32'd1);
    start_copy(16'h0060, 16'h0500, 8'd2);
    wait_done("t7_done_seen");
    chk("t7_mem", {8'd0, mem[16'h0400], mem[16'h0401], mem[16'h0402]}, 32'h009AABBC);
    chk("t7_other_dst_untouched", {24'd0, mem[16'h0500]}, 32'h000000EE);
    chk("t7_done_once", done_cnt - d0, 32'd1);
    chk_sb_empty("t7_sb_empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
